tmr32_pwm_seq: RTL and testbench

TMR32_PWM_SEQ -- requirements
Module: tmr32_pwm_seq

---
 rtl/tmr32_seq_pkg.sv | 40 ++++
 rtl/tmr32_seq_apbm.sv | 54 +++++
 rtl/tmr32_pwm_seq.sv | 191 +++++++++++++++++++
 tb/tb_tmr32_pwm_seq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmr32_seq_pkg.sv
// Shared constants, state/sequence enums and op-decode helpers for the timer PWM sequencer.
package tmr32_seq_pkg;

  localparam logic [7:0]  REG_LOAD  = 8'h20;
  localparam logic [7:0]  REG_CMP   = 8'h10;
  localparam logic [7:0]  REG_CTRL  = 8'h30;
  localparam logic [7:0]  REG_IC    = 8'h48;

  localparam logic [31:0] CTRL_RUN  = 32'h3;
  localparam logic [31:0] CTRL_HALT = 32'h0;
  localparam logic [31:0] IC_OVF    = 32'h1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_WAIT} seq_state_e;
  typedef enum logic [1:0] {SQ_START, SQ_STEP, SQ_END, SQ_STOP} seq_kind_e;
  typedef enum logic [2:0] {OP_LOAD, OP_CMP, OP_RUN, OP_IC, OP_HALT} op_e;

  // Each sequence kind is a short fixed list of register writes.
  function automatic op_e op_at(seq_kind_e k, logic [1:0] i);
    op_e op;
    op = OP_HALT;
    case (k)
      SQ_START: op = (i == 2'd0) ? OP_LOAD : (i == 2'd1) ? OP_CMP : OP_RUN;
      SQ_STEP:  op = (i == 2'd0) ? OP_LOAD : (i == 2'd1) ? OP_CMP : OP_IC;
      SQ_END:   op = (i == 2'd0) ? OP_IC : OP_HALT;
      default:  op = OP_HALT;
    endcase
    return op;
  endfunction

  function automatic logic op_last(seq_kind_e k, logic [1:0] i);
    logic last;
    case (k)
      SQ_START, SQ_STEP: last = (i == 2'd2);
      SQ_END:            last = (i == 2'd1);
      default:           last = 1'b1;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/tmr32_seq_apbm.sv
// APB write master: one SETUP cycle then ACCESS until PREADY; a new request may be
// accepted in the completing ACCESS cycle so writes run back to back.
module tmr32_seq_apbm
  import tmr32_seq_pkg::*;
(
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        req,
  input  logic [7:0]  addr,
  input  logic [31:0] data,
  output logic        ack,
  output logic        M_PSEL,
  output logic        M_PENABLE,
  output logic        M_PWRITE,
  output logic [7:0]  M_PADDR,
  output logic [31:0] M_PWDATA,
  input  logic        M_PREADY
);

  seq_state_e ph, ph_d;
  logic       accept;

  assign ack    = (ph == ST_ACCESS) && M_PREADY;
  assign accept = req && ((ph == ST_IDLE) || ack);

  always_comb begin
    ph_d = ph;
    case (ph)
      ST_IDLE:   if (accept) ph_d = ST_SETUP;
      ST_SETUP:  ph_d = ST_ACCESS;
      ST_ACCESS: if (ack) ph_d = accept ? ST_SETUP : ST_IDLE;
      default:   ph_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ph       <= ST_IDLE;
      M_PADDR  <= '0;
      M_PWDATA <= '0;
    end else begin
      ph <= ph_d;
      if (accept) begin
        M_PADDR  <= addr;
        M_PWDATA <= data;
      end
    end
  end

  assign M_PSEL    = (ph != ST_IDLE);
  assign M_PENABLE = (ph == ST_ACCESS);
  assign M_PWRITE  = M_PSEL;

endmodule

// File: rtl/tmr32_pwm_seq.sv
// Step-table PWM sequencer: on each timer overflow, reprograms LOAD/CMP of a timer
// through an APB write master, with optional looping, stop and overrun detection.
module tmr32_pwm_seq
  import tmr32_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic          tbl_we,
  input  logic [AW-1:0] tbl_addr,
  input  logic [31:0]   tbl_load,
  input  logic [31:0]   tbl_cmp,
  input  logic [AW:0]   len,
  input  logic          loop,
  input  logic          start,
  input  logic          stop,
  input  logic          evt,
  output logic          M_PSEL,
  output logic          M_PENABLE,
  output logic          M_PWRITE,
  output logic [7:0]    M_PADDR,
  output logic [31:0]   M_PWDATA,
  input  logic          M_PREADY,
  output logic          busy,
  output logic [AW-1:0] step,
  output logic          done,
  output logic          overrun
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [31:0] load_mem [DEPTH];
  logic [31:0] cmp_mem  [DEPTH];

  seq_state_e    state, state_d;
  seq_kind_e     kind, kind_d, iss_kind;
  logic [1:0]    opi, opi_d, iss_idx;
  logic [AW-1:0] step_d, tidx;
  logic [AW:0]   nxt;
  logic          stop_pend, stop_pend_d, stopping;
  logic          done_d, clr_ovr, issue, evt_q, evt_rise, ack, len_ok;
  logic [31:0]   cmp_hold;
  op_e           iss_op;
  logic [7:0]    req_addr;
  logic [31:0]   req_data;

  always_ff @(posedge PCLK) begin
    if (tbl_we) begin
      load_mem[tbl_addr] <= tbl_load;
      cmp_mem[tbl_addr]  <= tbl_cmp;
    end
  end

  assign evt_rise = evt && !evt_q;
  assign len_ok   = (len != '0) && (len <= DEPTH_L);
  assign stopping = stop || stop_pend;
  assign nxt      = {1'b0, step} + (AW+1)'(1);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= ST_IDLE;
      kind      <= SQ_START;
      opi       <= '0;
      step      <= '0;
      stop_pend <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      evt_q     <= 1'b0;
      cmp_hold  <= '0;
    end else begin
      state     <= state_d;
      kind      <= kind_d;
      opi       <= opi_d;
      step      <= step_d;
      stop_pend <= stop_pend_d;
      done      <= done_d;
      evt_q     <= evt;
      // CMP for a step is latched alongside its LOAD so both come from one table snapshot
      if (issue && (iss_op == OP_LOAD)) cmp_hold <= cmp_mem[tidx];
      if (evt_rise && (state != ST_WAIT)) overrun <= 1'b1;
      else if (clr_ovr)                   overrun <= 1'b0;
    end
  end

  always_comb begin
    state_d     = state;
    kind_d      = kind;
    opi_d       = opi;
    step_d      = step;
    stop_pend_d = stop_pend;
    done_d      = 1'b0;
    clr_ovr     = 1'b0;
    issue       = 1'b0;
    iss_kind    = kind;
    iss_idx     = opi;
    tidx        = step;
    case (state)
      ST_IDLE: begin
        if (start && len_ok) begin
          issue    = 1'b1;
          iss_kind = SQ_START;
          iss_idx  = '0;
          tidx     = '0;
          step_d   = '0;
          clr_ovr  = 1'b1;
        end
      end
      ST_SETUP: begin
        state_d     = ST_ACCESS;
        stop_pend_d = stopping;
      end
      ST_ACCESS: begin
        stop_pend_d = stopping;
        if (ack) begin
          // A pending stop replaces the rest of the sequence with a single HALT,
          // unless the write just completed was already the closing HALT.
          if (stopping && (kind != SQ_STOP) && !((kind == SQ_END) && op_last(kind, opi))) begin
            issue    = 1'b1;
            iss_kind = SQ_STOP;
            iss_idx  = '0;
          end else if (!op_last(kind, opi)) begin
            issue   = 1'b1;
            iss_idx = opi + 2'd1;
          end else if ((kind == SQ_START) || (kind == SQ_STEP)) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
            done_d  = (kind == SQ_END) && !stopping;
          end
        end
      end
      ST_WAIT: begin
        if (stop) begin
          issue    = 1'b1;
          iss_kind = SQ_STOP;
          iss_idx  = '0;
        end else if (evt_rise) begin
          issue   = 1'b1;
          iss_idx = '0;
          if ((nxt >= len) && !loop) begin
            iss_kind = SQ_END;
          end else begin
            iss_kind = SQ_STEP;
            tidx     = (nxt >= len) ? '0 : nxt[AW-1:0];
            step_d   = tidx;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (issue) begin
      state_d = ST_SETUP;
      kind_d  = iss_kind;
      opi_d   = iss_idx;
    end
    if (state_d == ST_IDLE) stop_pend_d = 1'b0;
  end

  always_comb begin
    iss_op   = op_at(iss_kind, iss_idx);
    req_addr = REG_CTRL;
    req_data = CTRL_HALT;
    case (iss_op)
      OP_LOAD: begin req_addr = REG_LOAD; req_data = load_mem[tidx]; end
      OP_CMP:  begin req_addr = REG_CMP;  req_data = cmp_hold;       end
      OP_RUN:  begin req_addr = REG_CTRL; req_data = CTRL_RUN;       end
      OP_IC:   begin req_addr = REG_IC;   req_data = IC_OVF;         end
      default: begin req_addr = REG_CTRL; req_data = CTRL_HALT;      end
    endcase
  end

  assign busy = (state != ST_IDLE);

  tmr32_seq_apbm u_apbm (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .req       (issue),
    .addr      (req_addr),
    .data      (req_data),
    .ack       (ack),
    .M_PSEL    (M_PSEL),
    .M_PENABLE (M_PENABLE),
    .M_PWRITE  (M_PWRITE),
    .M_PADDR   (M_PADDR),
    .M_PWDATA  (M_PWDATA),
    .M_PREADY  (M_PREADY)
  );

endmodule

// File: tb/tb_tmr32_pwm_seq.sv
// Directed bench for tmr32_pwm_seq: write-sequence tables plus hand-built corner cases.
module tb_tmr32_pwm_seq;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          PCLK, PRESET, tbl_we, loop, start, stop, evt, M_PREADY;
  logic [AW-1:0] tbl_addr;
  logic [31:0]   tbl_load, tbl_cmp;
  logic [AW:0]   len;
  logic          M_PSEL, M_PENABLE, M_PWRITE, busy, done, overrun;
  logic [7:0]    M_PADDR;
  logic [31:0]   M_PWDATA;
  logic [AW-1:0] step;

  int n_chk, n_fail, done_cnt;
  logic [31:0] mdl_load [DEPTH];
  logic [31:0] mdl_cmp  [DEPTH];

  typedef struct {
    bit            evt_before;
    logic [7:0]    addr;
    logic [31:0]   data;
    logic [AW-1:0] step;
  } wr_vec_t;

  wr_vec_t       t1 [8];
  logic [AW-1:0] t2_steps [3];

  tmr32_pwm_seq #(.DEPTH(DEPTH), .AW(AW)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_load(tbl_load), .tbl_cmp(tbl_cmp), .len(len), .loop(loop),
    .start(start), .stop(stop), .evt(evt), .M_PSEL(M_PSEL), .M_PENABLE(M_PENABLE),
    .M_PWRITE(M_PWRITE), .M_PADDR(M_PADDR), .M_PWDATA(M_PWDATA), .M_PREADY(M_PREADY),
    .busy(busy), .step(step), .done(done), .overrun(overrun)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  // Bus protocol monitor: SETUP lasts one cycle, address/data hold through ACCESS.
  logic        prev_setup;
  logic [7:0]  h_addr;
  logic [31:0] h_data;
  always @(negedge PCLK) begin
    if (PRESET) begin
      prev_setup = 1'b0;
    end else begin
      if (prev_setup) check("apb_setup_then_access", {M_PSEL, M_PENABLE}, 2'b11);
      if (M_PSEL && !M_PENABLE) begin
        h_addr = M_PADDR;
        h_data = M_PWDATA;
        check("apb_pwrite", M_PWRITE, 1);
        check("apb_addr_align", M_PADDR[2:0], 0);
      end else if (M_PSEL && M_PENABLE) begin
        check("apb_addr_stable", M_PADDR, h_addr);
        check("apb_data_stable", M_PWDATA, h_data);
      end
      prev_setup = M_PSEL && !M_PENABLE;
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge PCLK); #1;
  endtask

  task automatic wait_write(output logic [7:0] a, output logic [31:0] d);
    bit got;
    got = 0; a = '0; d = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge PCLK);
      if (M_PSEL && M_PENABLE && M_PREADY) begin
        a = M_PADDR; d = M_PWDATA; got = 1;
      end
    end
    if (!got) check("write_timeout", 0, 1);
    tick();
  endtask

  task automatic expect_write(string name, logic [7:0] ea, logic [31:0] ed);
    logic [7:0]  a;
    logic [31:0] d;
    wait_write(a, d);
    check({name, "_addr"}, a, ea);
    check({name, "_data"}, d, ed);
  endtask

  task automatic write_tbl(int i, logic [31:0] ld, logic [31:0] cp);
    tbl_we = 1; tbl_addr = AW'(i); tbl_load = ld; tbl_cmp = cp;
    mdl_load[i] = ld; mdl_cmp[i] = cp;
    tick();
    tbl_we = 0;
  endtask

  task automatic do_start(logic [AW:0] l, logic lp);
    len = l; loop = lp; start = 1;
    tick();
    start = 0;
  endtask

  task automatic pulse_evt();
    evt = 1; tick(); evt = 0;
  endtask

  task automatic pulse_stop();
    stop = 1; tick(); stop = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0; done_cnt = 0;
    PRESET = 1; tbl_we = 0; tbl_addr = '0; tbl_load = '0; tbl_cmp = '0;
    len = '0; loop = 0; start = 0; stop = 0; evt = 0; M_PREADY = 1;

    t1[0] = '{1'b0, 8'h20, 32'd100, 3'd0};
    t1[1] = '{1'b0, 8'h10, 32'd50,  3'd0};
    t1[2] = '{1'b0, 8'h30, 32'h3,   3'd0};
    t1[3] = '{1'b1, 8'h20, 32'd200, 3'd1};
    t1[4] = '{1'b0, 8'h10, 32'd20,  3'd1};
    t1[5] = '{1'b0, 8'h48, 32'h1,   3'd1};
    t1[6] = '{1'b1, 8'h48, 32'h1,   3'd1};
    t1[7] = '{1'b0, 8'h30, 32'h0,   3'd1};
    t2_steps[0] = 3'd1; t2_steps[1] = 3'd0; t2_steps[2] = 3'd1;

    repeat (3) tick();
    check("rst_psel", M_PSEL, 0);
    check("rst_penable", M_PENABLE, 0);
    check("rst_busy", busy, 0);
    check("rst_step", step, 0);
    check("rst_paddr", M_PADDR, 0);
    check("rst_done_ovr", {done, overrun}, 0);
    PRESET = 0;
    tick();

    write_tbl(0, 32'd100, 32'd50);
    write_tbl(1, 32'd200, 32'd20);

    // Test 1: two-step one-shot sequence
    do_start(3'(2), 0);
    check("t1_busy", busy, 1);
    for (int i = 0; i < 8; i++) begin
      if (t1[i].evt_before) pulse_evt();
      expect_write($sformatf("t1_w%0d", i), t1[i].addr, t1[i].data);
      check($sformatf("t1_step%0d", i), step, t1[i].step);
    end
    check("t1_done_pulse", done, 1);
    check("t1_busy_end", busy, 0);
    tick();
    check("t1_done_clear", done, 0);
    check("t1_done_cnt", done_cnt, 1);

    // Test 2: looping sequence, steps 0,1,0,1
    do_start(3'(2), 1);
    expect_write("t2_load0", 8'h20, mdl_load[0]);
    expect_write("t2_cmp0", 8'h10, mdl_cmp[0]);
    expect_write("t2_run", 8'h30, 32'h3);
    check("t2_step_init", step, 0);
    for (int i = 0; i < 3; i++) begin
      pulse_evt();
      expect_write($sformatf("t2_load%0d", i), 8'h20, mdl_load[t2_steps[i]]);
      expect_write($sformatf("t2_cmp%0d", i), 8'h10, mdl_cmp[t2_steps[i]]);
      expect_write($sformatf("t2_ic%0d", i), 8'h48, 32'h1);
      check($sformatf("t2_step%0d", i), step, t2_steps[i]);
    end
    check("t2_wait_busy", busy, 1);
    pulse_stop();
    expect_write("t2_halt", 8'h30, 32'h0);
    check("t2_idle", busy, 0);
    check("t2_no_done", done_cnt, 1);

    // Test 3: PREADY stall during CMP, len=1 boundary
    do_start(3'(1), 0);
    expect_write("t3_load", 8'h20, 32'd100);
    M_PREADY = 0;
    @(negedge PCLK);
    check("t3_cmp_setup", {M_PSEL, M_PENABLE, M_PADDR}, {2'b10, 8'h10});
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge PCLK);
      check($sformatf("t3_stall%0d_ctl", i), {M_PSEL, M_PENABLE, M_PADDR}, {2'b11, 8'h10});
      check($sformatf("t3_stall%0d_data", i), M_PWDATA, 32'd50);
    end
    tick();
    M_PREADY = 1;
    @(negedge PCLK);
    check("t3_cmp_complete", {M_PSEL, M_PENABLE, M_PADDR}, {2'b11, 8'h10});
    tick();
    @(negedge PCLK);
    check("t3_next_setup", {M_PSEL, M_PENABLE, M_PADDR}, {2'b10, 8'h30});
    expect_write("t3_run", 8'h30, 32'h3);
    pulse_evt();
    expect_write("t3_ic", 8'h48, 32'h1);
    expect_write("t3_halt", 8'h30, 32'h0);
    check("t3_step_last", step, 0);
    tick();
    check("t3_done_cnt", done_cnt, 2);

    // Test 4: evt while a write is in flight
    do_start(3'(2), 0);
    pulse_evt();
    expect_write("t4_load", 8'h20, 32'd100);
    expect_write("t4_cmp", 8'h10, 32'd50);
    expect_write("t4_run", 8'h30, 32'h3);
    check("t4_overrun", overrun, 1);
    check("t4_step", step, 0);
    check("t4_busy", busy, 1);
    pulse_stop();
    expect_write("t4_halt", 8'h30, 32'h0);
    check("t4_overrun_sticky", overrun, 1);

    // Test 5: stop during LOAD; restart clears overrun; bad lengths ignored
    do_start(3'(2), 0);
    check("t5_overrun_clr", overrun, 0);
    pulse_stop();
    expect_write("t5_load", 8'h20, 32'd100);
    expect_write("t5_halt", 8'h30, 32'h0);
    check("t5_idle", {busy, done}, 0);
    check("t5_no_done", done_cnt, 2);
    do_start(3'(0), 0);
    @(negedge PCLK);
    check("t5_len0_ignored", {busy, M_PSEL}, 0);
    tick();
    do_start(4'(DEPTH + 1), 0);
    @(negedge PCLK);
    check("t5_len_big_ignored", {busy, M_PSEL}, 0);
    tick();

    // Test 6: reset during ACCESS; table survives reset
    do_start(3'(2), 0);
    pulse_evt();
    check("t6_pre_access", {M_PSEL, M_PENABLE, overrun}, 3'b111);
    PRESET = 1;
    #1;
    check("t6_rst_ctl", {M_PSEL, M_PENABLE, M_PWRITE}, 0);
    check("t6_rst_status", {busy, done, overrun}, 0);
    check("t6_rst_step", step, 0);
    check("t6_rst_paddr", M_PADDR, 0);
    check("t6_rst_pwdata", M_PWDATA, 0);
    tick();
    PRESET = 0;
    tick();
    do_start(3'(1), 0);
    expect_write("t6_load_kept", 8'h20, 32'd100);
    expect_write("t6_cmp_kept", 8'h10, 32'd50);
    expect_write("t6_run", 8'h30, 32'h3);
    pulse_stop();
    expect_write("t6_halt", 8'h30, 32'h0);
    check("t6_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
